// File: rtl/soc_map_pkg.sv
// Shared SoC address map: register window base, register offsets, read-source
// encoding and a byte-merge helper for the data-side SRAM responder.
package soc_map_pkg;

  localparam logic [31:0] CONF_BASE_DEFAULT = 32'h1faf_0000;

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_COUNT   = 16'hF008;
  localparam logic [15:0] OFF_COMPARE = 16'hF00C;
  localparam logic [15:0] OFF_STATUS  = 16'hF010;

  // Which source drives data_sram_rdata after the most recent serviced access.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_REG  = 2'd2
  } rd_src_e;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port word RAM with four byte lanes, synchronous read-first.
// No reset on contents or output so it maps onto block RAM.
module byte_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Read old contents and write enabled lanes on the same edge (read-first).
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: decodes each access into the local RAM or the
// configuration register window (LED, SWITCH, COUNT, COMPARE, STATUS) and
// returns read data one cycle later. Also owns the free-running timer.
//
// Access protocol: data_sram_en is the only qualifier; there is no ready, so
// every cycle with en=1 is serviced at that rising edge. data_sram_wen!=0
// makes it a write, and the read data for the same location (pre-write value)
// appears after that edge and is held until the next serviced access.
module data_sram_resp
  import soc_map_pkg::*;
#(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_int
);

  logic        live_q;
  rd_src_e     rd_src_q;
  logic [31:0] reg_q;
  logic [31:0] ram_q;
  logic [15:0] led_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_int_q;

  logic        acc;
  logic        sel_reg;
  logic        wr_reg;
  logic [13:0] off;
  logic        hit_led, hit_switch, hit_count, hit_compare, hit_status;
  logic [31:0] reg_rdata;
  logic [31:0] led_wr;
  logic [31:0] count_next;
  logic        timer_set;
  logic        timer_clr;
  logic        unused_bits;

  // The first edge after reset release only arms live_q, so an access that is
  // presented in the deassertion cycle is dropped.
  assign acc     = data_sram_en & live_q;
  assign sel_reg = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign wr_reg  = acc & sel_reg & (|data_sram_wen);
  assign off     = data_sram_addr[15:2];

  assign hit_led     = (off == OFF_LED[15:2]);
  assign hit_switch  = (off == OFF_SWITCH[15:2]);
  assign hit_count   = (off == OFF_COUNT[15:2]);
  assign hit_compare = (off == OFF_COMPARE[15:2]);
  assign hit_status  = (off == OFF_STATUS[15:2]);

  assign led_wr      = merge_bytes({16'h0000, led_q}, data_sram_wdata, data_sram_wen);
  assign unused_bits = ^{data_sram_addr[1:0], led_wr[31:16]};

  // RAM: upper address bits above the word index simply alias.
  byte_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (acc & ~sel_reg),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_q)
  );

  // Register-window read mux; unmapped offsets read as zero.
  always_comb begin
    reg_rdata = 32'h0;
    if (hit_led)          reg_rdata = {16'h0000, led_q};
    else if (hit_switch)  reg_rdata = {24'h0, switch};
    else if (hit_count)   reg_rdata = count_q;
    else if (hit_compare) reg_rdata = compare_q;
    else if (hit_status)  reg_rdata = {31'h0, timer_int_q};
  end

  // Timer: a COUNT write replaces the increment; interrupt sets on the edge
  // where COUNT takes the COMPARE value, and set beats a same-edge clear.
  always_comb begin
    count_next = count_q + 32'd1;
    if (wr_reg && hit_count) count_next = merge_bytes(count_q, data_sram_wdata, data_sram_wen);
    timer_set = (count_next == compare_q) && (compare_q != 32'h0);
    timer_clr = wr_reg && hit_status && data_sram_wen[0] && data_sram_wdata[0];
  end

  // Reset-release arming flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) live_q <= 1'b0;
    else         live_q <= 1'b1;
  end

  // Read-data source and captured register read value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_src_q <= SRC_NONE;
      reg_q    <= 32'h0;
    end else if (acc) begin
      rd_src_q <= sel_reg ? SRC_REG : SRC_RAM;
      if (sel_reg) reg_q <= reg_rdata;
    end
  end

  // Writable registers and timer state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q       <= 16'h0;
      count_q     <= 32'h0;
      compare_q   <= 32'h0;
      timer_int_q <= 1'b0;
    end else begin
      count_q <= count_next;
      if (wr_reg && hit_led)     led_q     <= led_wr[15:0];
      if (wr_reg && hit_compare) compare_q <= merge_bytes(compare_q, data_sram_wdata, data_sram_wen);
      if (timer_set)             timer_int_q <= 1'b1;
      else if (timer_clr)        timer_int_q <= 1'b0;
    end
  end

  // Output read data; zero until the first serviced access after reset.
  always_comb begin
    case (rd_src_q)
      SRC_RAM: data_sram_rdata = ram_q;
      SRC_REG: data_sram_rdata = reg_q;
      default: data_sram_rdata = 32'h0;
    endcase
  end

  assign led       = led_q;
  assign timer_int = timer_int_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: table of single-cycle RAM/register vectors plus
// hand-written timer, wrap and mid-run reset sequences.
module tb_data_sram_resp;

  localparam logic [31:0] CB = 32'h1faf_0000;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        timer_int;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  data_sram_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .timer_int       (timer_int)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one access at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic add(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] s, input logic c, input logic [31:0] r, input logic [15:0] l);
    vecs.push_back('{e, w, a, d, s, c, r, l});
  endtask

  initial begin
    logic [31:0] exp_v;
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;

    // Vector table: en, wen, addr, wdata, switch, check rdata, rdata, led
    add(1, 4'hF, 32'h10,        32'h1122_3344, 8'h00, 0, 32'h0,         16'h0000);
    add(1, 4'h0, 32'h10,        32'h0,         8'h00, 1, 32'h1122_3344, 16'h0000);
    add(1, 4'h5, 32'h10,        32'hAABB_CCDD, 8'h00, 1, 32'h1122_3344, 16'h0000);
    add(1, 4'h0, 32'h10,        32'h0,         8'h00, 1, 32'h11BB_33DD, 16'h0000);
    add(1, 4'hF, 32'h10,        32'hDEAD_BEEF, 8'h00, 1, 32'h11BB_33DD, 16'h0000);
    add(1, 4'h0, 32'h10,        32'h0,         8'h00, 1, 32'hDEAD_BEEF, 16'h0000);
    add(0, 4'h0, 32'h10,        32'h0,         8'h00, 1, 32'hDEAD_BEEF, 16'h0000);
    add(0, 4'hF, 32'h10,        32'h0,         8'h00, 1, 32'hDEAD_BEEF, 16'h0000);
    add(1, 4'h0, 32'h10,        32'h0,         8'h00, 1, 32'hDEAD_BEEF, 16'h0000);
    add(1, 4'hF, 32'h4010,      32'h5566_7788, 8'h00, 1, 32'hDEAD_BEEF, 16'h0000);
    add(1, 4'h0, 32'h10,        32'h0,         8'h00, 1, 32'h5566_7788, 16'h0000);
    add(1, 4'hF, 32'h20,        32'hCAFE_F00D, 8'h00, 0, 32'h0,         16'h0000);
    add(1, 4'hF, CB | 32'hF000, 32'hFFFF_A5A5, 8'h00, 1, 32'h0,         16'hA5A5);
    add(1, 4'h0, CB | 32'hF000, 32'h0,         8'h00, 1, 32'h0000_A5A5, 16'hA5A5);
    add(1, 4'h2, CB | 32'hF000, 32'h0000_3C00, 8'h00, 1, 32'h0000_A5A5, 16'h3CA5);
    add(1, 4'h0, CB | 32'hF004, 32'h0,         8'h3C, 1, 32'h0000_003C, 16'h3CA5);
    add(1, 4'h0, CB | 32'hF020, 32'h0,         8'h3C, 1, 32'h0,         16'h3CA5);
    add(1, 4'hF, CB | 32'hF020, 32'hFFFF_FFFF, 8'h00, 1, 32'h0,         16'h3CA5);
    add(1, 4'h0, 32'h20,        32'h0,         8'h00, 1, 32'hCAFE_F00D, 16'h3CA5);
    add(1, 4'h0, CB | 32'hF000, 32'h0,         8'h00, 1, 32'h0000_3CA5, 16'h3CA5);
    add(0, 4'h0, 32'h0,         32'h0,         8'h00, 1, 32'h0000_3CA5, 16'h3CA5);
    add(1, 4'h0, 32'h10,        32'h0,         8'h00, 1, 32'h5566_7788, 16'h3CA5);

    // Reset state
    #2;
    check("reset rdata", rdata, 32'h0);
    check("reset led", {16'h0, led}, 32'h0);
    check("reset timer_int", {31'h0, timer_int}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle();

    // Table-driven RAM and register vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en = vecs[i].en; wen = vecs[i].wen; addr = vecs[i].addr; wdata = vecs[i].wdata; sw = vecs[i].sw;
      if (vecs[i].chk_rd) exp_q.push_back(vecs[i].exp_rd);
      @(posedge clk);
      #1;
      if (vecs[i].chk_rd) begin
        exp_v = exp_q.pop_front();
        check($sformatf("row%0d rdata", i), rdata, exp_v);
      end
      check($sformatf("row%0d led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end

    // Timer match: COMPARE=20, COUNT=10, interrupt ten edges after the COUNT write
    check("timer idle", {31'h0, timer_int}, 32'h0);
    cycle(1, 4'hF, CB | 32'hF00C, 32'd20);
    cycle(1, 4'hF, CB | 32'hF008, 32'd10);
    cycle(1, 4'h0, CB | 32'hF008, 32'h0);
    check("count readback", rdata, 32'd10);
    check("timer edge1", {31'h0, timer_int}, 32'h0);
    for (int j = 2; j <= 9; j++) begin
      idle();
      check($sformatf("timer edge%0d", j), {31'h0, timer_int}, 32'h0);
    end
    idle();
    check("timer edge10 set", {31'h0, timer_int}, 32'h1);
    cycle(1, 4'h0, CB | 32'hF010, 32'h0);
    check("status read", rdata, 32'h1);
    idle();
    check("timer sticky", {31'h0, timer_int}, 32'h1);
    cycle(1, 4'h1, CB | 32'hF010, 32'h1);
    check("timer cleared", {31'h0, timer_int}, 32'h0);

    // Clear on the match edge: set wins
    cycle(1, 4'hF, CB | 32'hF008, 32'd10);
    for (int j = 1; j <= 9; j++) idle();
    check("timer before match", {31'h0, timer_int}, 32'h0);
    cycle(1, 4'h1, CB | 32'hF010, 32'h1);
    check("set beats clear", {31'h0, timer_int}, 32'h1);
    cycle(1, 4'h0, CB | 32'hF00C, 32'h0);
    check("compare readback", rdata, 32'd20);

    // COUNT wrap
    cycle(1, 4'hF, CB | 32'hF008, 32'hFFFF_FFFF);
    cycle(1, 4'h0, CB | 32'hF008, 32'h0);
    check("count max", rdata, 32'hFFFF_FFFF);
    cycle(1, 4'h0, CB | 32'hF008, 32'h0);
    check("count wrap", rdata, 32'h0);

    // Mid-run reset
    cycle(1, 4'h0, 32'h20, 32'h0);
    check("pre-reset rdata", rdata, 32'hCAFE_F00D);
    check("pre-reset timer", {31'h0, timer_int}, 32'h1);
    check("pre-reset led", {16'h0, led}, 32'h0000_3CA5);
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
    resetn = 1'b0;
    #1;
    check("async rdata", rdata, 32'h0);
    check("async led", {16'h0, led}, 32'h0);
    check("async timer", {31'h0, timer_int}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("held rdata", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    en = 1'b1; wen = 4'hF; addr = CB | 32'hF000; wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    check("release access dropped led", {16'h0, led}, 32'h0);
    check("release access rdata", rdata, 32'h0);
    cycle(1, 4'h0, CB | 32'hF000, 32'h0);
    check("post-reset led read", rdata, 32'h0);
    cycle(1, 4'h0, CB | 32'hF008, 32'h0);
    check("post-reset count", rdata, 32'd2);
    cycle(1, 4'h0, CB | 32'hF00C, 32'h0);
    check("post-reset compare", rdata, 32'h0);
    cycle(1, 4'h0, CB | 32'hF010, 32'h0);
    check("post-reset status", rdata, 32'h0);
    cycle(1, 4'h0, 32'h20, 32'h0);
    check("ram kept 0x20", rdata, 32'hCAFE_F00D);
    cycle(1, 4'h0, 32'h10, 32'h0);
    check("ram kept 0x10", rdata, 32'h5566_7788);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter RAM_AW, default 12, meaning RAM word-address width (4096 words, 16 KiB).
REQ-002 SHALL have parameter CONF_BASE, default 32'h1faf_0000, meaning base of the 64 KiB register window.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_sram_en  input  1  access enable.
REQ-006 SHALL have port data_sram_wen  input  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-007 SHALL have port data_sram_addr  input  32  physical byte address; bits [1:0] are ignored.
REQ-008 SHALL have port data_sram_wdata  input  32  write data.
REQ-009 SHALL have port data_sram_rdata  output  32  read data.
REQ-010 SHALL have port switch  input  8  external switch levels.
REQ-011 SHALL have port led  output  16  LED register value.
REQ-012 SHALL have port timer_int  output  1  sticky timer interrupt.

Function
REQ-013 SHALL decode as follows: addr[31:16]==CONF_BASE[31:16] selects the register window; any other address selects RAM word addr[RAM_AW+1:2], with upper bits aliased.
REQ-014 SHALL treat an access as valid only when data_sram_en=1; wen with en=0 SHALL have no effect.
REQ-015 SHALL have read latency exactly 1 cycle: rdata after edge N reflects the location addressed at edge N.
REQ-016 SHALL hold data_sram_rdata unchanged across cycles with en=0.
REQ-017 SHALL be read-first: a read with wen!=0 returns the pre-write contents.
REQ-018 SHALL update only the enabled bytes on a write to RAM or to a writable register.
REQ-019 SHALL map these register offsets: 0xF000 LED (RW, bits [15:0], upper bits read 0); 0xF004 SWITCH (RO, {24'b0, switch}); 0xF008 COUNT (RW); 0xF00C COMPARE (RW); 0xF010 STATUS (bit0=timer_int; writing 1 to bit0 clears it).
REQ-020 SHALL return 0 for unmapped register offsets and ignore writes to them.
REQ-021 SHALL increment COUNT by 1 every cycle and wrap at 32'hFFFF_FFFF to 0; in a cycle where COUNT is written, the merged write value loads and no increment occurs.
REQ-022 SHALL set timer_int on the edge where COUNT==COMPARE and COMPARE!=0, and hold it until cleared.
REQ-023 SHALL give set priority over clear when set and a STATUS clear occur on the same edge.
REQ-024 SHALL sample switch unsynchronised; the value read is switch at the access edge.
REQ-025 SHALL drive led combinationally from the LED register.

Reset
REQ-026 SHALL, while resetn=0, force data_sram_rdata=0, LED=0, COUNT=0, COMPARE=0 and timer_int=0, asynchronously.
REQ-027 SHALL not reset RAM contents; reads of unwritten RAM are undefined (X in simulation).
REQ-028 SHALL ignore any access presented in the same cycle resetn deasserts; the first serviced access is at the next edge.

Structure
REQ-029 SHALL place register offsets (0xF000 to 0xF010) and the CONF_BASE default in shared package soc_map_pkg.
REQ-030 SHALL implement the RAM as sub-module byte_ram (RAM_AW-deep, 4 byte lanes, synchronous read-first), inferable as block RAM.
REQ-031 SHALL be 120-400 lines of RTL including byte_ram.

Verification
REQ-032 SHALL cover: write 0x1122_3344 to 0x0000_0010 with wen=4'hF, then read -> rdata=0x1122_3344 one cycle after the read edge.
REQ-033 SHALL cover: a partial write of wen=4'b0101 with 0xAABB_CCDD over 0x1122_3344 -> readback 0x11BB_33DD.
REQ-034 SHALL cover: a simultaneous read and write of the same RAM word -> old value returned, new value seen on the next read.
REQ-035 SHALL cover: COMPARE=20 then COUNT=10 written -> timer_int rises 10 cycles after the COUNT write edge; writing STATUS=1 clears it; a clear in the match cycle leaves timer_int=1.
REQ-036 SHALL cover: LED write 0xFFFF_A5A5 -> led=16'hA5A5 and readback 0x0000_A5A5; switch=8'h3C -> SWITCH reads 0x0000_003C; offset 0xF020 reads 0.
REQ-037 SHALL cover: resetn pulsed low mid-run -> rdata, led, timer_int and COUNT are 0 immediately, with RAM data written before reset still readable afterwards.
